// File: rtl/fu_multicycle.sv
// Function unit behind the register file. Logic, ADD and SUB finish in one cycle.
// MUL, DIV and MOD run iteratively for WIDTH cycles; F/flags/DA_out are written on done.
module fu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       DA_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic [2:0]       DA_out,
  output logic             RW,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_AND = 3'b010;
  localparam logic [2:0] FS_OR  = 3'b011;
  localparam logic [2:0] FS_XOR = 3'b100;
  localparam logic [2:0] FS_MUL = 3'b101;
  localparam logic [2:0] FS_DIV = 3'b110;
  localparam logic [2:0] FS_MOD = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, next_state_s;
  logic [2:0]       fs_r, da_r, da_out_r;
  logic [WIDTH-1:0] op_r, hi_r, lo_r, f_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r, done_r, rw_r, v_r, c_r, n_r, z_r;

  logic             accept_s, last_s, load_s;
  logic [WIDTH:0]   sum_s, shifted_s, diff_s, add_s, sub_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s, res_f_s;
  logic             res_c_s, res_v_s;

  assign accept_s = (state_r == IDLE) && start;
  assign last_s   = (state_r == EXEC) && (cnt_r == LAST);
  assign load_s   = (accept_s && (FS < FS_MUL)) || last_s;

  // Next-state logic for the IDLE/EXEC/DONE sequencer.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = (FS >= FS_MUL) ? EXEC : DONE;
        else       next_state_s = IDLE;
      end
      EXEC: begin
        if (cnt_r == LAST) next_state_s = DONE;
        else               next_state_s = EXEC;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // One iteration step: hi:lo is product/multiplier for MUL, remainder/quotient for DIV/MOD.
  always_comb begin
    sum_s     = '0;
    shifted_s = '0;
    diff_s    = '0;
    step_hi_s = hi_r;
    step_lo_s = lo_r;
    if (fs_r == FS_MUL) begin
      sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_r} : {(WIDTH+1){1'b0}});
      step_hi_s = sum_s[WIDTH:1];
      step_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end else begin
      // A zero divisor never goes negative, so quotient fills with ones and remainder ends as A.
      shifted_s = {hi_r, lo_r[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, op_r};
      if (diff_s[WIDTH]) begin
        step_hi_s = shifted_s[WIDTH-1:0];
        step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end else begin
        step_hi_s = diff_s[WIDTH-1:0];
        step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Result and C/V selection: single-cycle ops from live inputs, iterative ops from the final step.
  always_comb begin
    add_s   = {1'b0, A} + {1'b0, B};
    sub_s   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    res_f_s = '0;
    res_c_s = 1'b0;
    res_v_s = 1'b0;
    if (state_r == EXEC) begin
      case (fs_r)
        FS_MUL: begin
          res_f_s = step_lo_s;
          res_c_s = |step_hi_s;
          res_v_s = |step_hi_s;
        end
        FS_DIV: begin
          res_f_s = step_lo_s;
          res_v_s = (op_r == {WIDTH{1'b0}});
        end
        FS_MOD: begin
          res_f_s = step_hi_s;
          res_v_s = (op_r == {WIDTH{1'b0}});
        end
        default: res_f_s = step_lo_s;
      endcase
    end else begin
      case (FS)
        FS_ADD: begin
          res_f_s = add_s[WIDTH-1:0];
          res_c_s = add_s[WIDTH];
          res_v_s = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
        end
        FS_SUB: begin
          res_f_s = sub_s[WIDTH-1:0];
          res_c_s = sub_s[WIDTH];
          res_v_s = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
        end
        FS_AND:  res_f_s = A & B;
        FS_OR:   res_f_s = A | B;
        FS_XOR:  res_f_s = A ^ B;
        default: res_f_s = '0;
      endcase
    end
  end

  // Sequencer state and handshake outputs; done/RW/busy are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rw_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
      rw_r    <= (next_state_s == DONE);
    end
  end

  // Operand capture, iteration registers and the held result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_r     <= 3'b000;
      da_r     <= 3'b000;
      op_r     <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      cnt_r    <= '0;
      f_r      <= '0;
      da_out_r <= 3'b000;
      v_r      <= 1'b0;
      c_r      <= 1'b0;
      n_r      <= 1'b0;
      z_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        fs_r  <= FS;
        da_r  <= DA_in;
        cnt_r <= '0;
        hi_r  <= '0;
        lo_r  <= (FS == FS_MUL) ? B : A;
        op_r  <= (FS == FS_MUL) ? A : B;
      end else if (state_r == EXEC) begin
        hi_r  <= step_hi_s;
        lo_r  <= step_lo_s;
        cnt_r <= cnt_r + CW'(1);
      end
      if (load_s) begin
        f_r      <= res_f_s;
        c_r      <= res_c_s;
        v_r      <= res_v_s;
        n_r      <= res_f_s[WIDTH-1];
        z_r      <= (res_f_s == {WIDTH{1'b0}});
        da_out_r <= (state_r == EXEC) ? da_r : DA_in;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign RW     = rw_r;
  assign F      = f_r;
  assign DA_out = da_out_r;
  assign V      = v_r;
  assign C      = c_r;
  assign N      = n_r;
  assign Z      = z_r;

endmodule
